pong_game_ctrl: RTL and testbench

Game-flow sequencer for the pong design. It sits between the VGA timing generator and the pong rendering/physics logic and decides when the ball may move. It tracks score and lives and walks the game through idle, serve, play, point-pause and game-over. It consumes the ready button, a per-frame tick and ball hit/miss events, and produces the run enable, ball re-centre pulse and scoreboard values.

---
 rtl/pong_game_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl - game-flow sequencer for the pong design.
// Walks IDLE -> SERVE -> PLAY -> POINT/OVER, keeps a two-digit BCD score,
// the remaining lives and the speed level, and gates ball motion (run_en).
// Optional feature macro: PONG_SPEEDUP_EN builds the paddle-hit counter that
// raises level; when it is undefined, level is tied to 0.
module pong_game_ctrl #(
  parameter int LIVES          = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int POINT_FRAMES   = 30,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_button,
  input  logic       frame_tick,
  input  logic       ball_hit,
  input  logic       ball_miss,
  output logic [2:0] state,
  output logic       run_en,
  output logic       ball_reset,
  output logic [7:0] score_bcd,
  output logic [2:0] lives,
  output logic [1:0] level,
  output logic       game_over
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  // Reject parameter sets the counters and output widths cannot represent.
  if (LIVES < 1 || LIVES > 7 || SERVE_FRAMES < 1 || SERVE_FRAMES > 255 ||
      POINT_FRAMES < 1 || POINT_FRAMES > 255 || HITS_PER_LEVEL < 1 ||
      HITS_PER_LEVEL > 256 || MAX_LEVEL < 0 || MAX_LEVEL > 3) begin : g_param_check
    $error("pong_game_ctrl: parameter out of range");
  end

  logic       r_sync1, r_sync2, r_btn_prev;
  logic [1:0] r_fill;
  logic [2:0] r_state;
  logic       r_entry;
  logic [7:0] r_cnt;
  logic [7:0] r_score;
  logic [2:0] r_lives;
  logic       r_run_en, r_ball_reset, r_game_over;

  logic       w_start, w_game_start, w_tick_counted, w_state_change;
  logic       w_lose_life, w_scored;
  logic [2:0] w_next_state;
  logic [7:0] w_score_inc;

  // Synchronise the button and keep its last settled value for edge detection.
  // The synchronizer emits reset zeros for two cycles; the edge flop keeps its
  // reset value of 1 until real samples reach r_sync2, so a button held
  // through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_fill     <= 2'b00;
      r_btn_prev <= 1'b1;
    end else begin
      r_sync1 <= ready_button;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      if (r_fill[1]) r_btn_prev <= r_sync2;
    end
  end

  assign w_start        = r_sync2 & ~r_btn_prev;
  assign w_game_start   = w_start & ((r_state == ST_IDLE) | (r_state == ST_OVER));
  assign w_tick_counted = frame_tick & ~r_entry;
  assign w_lose_life    = (r_state == ST_PLAY) & ball_miss & (r_lives != 3'd0);
  assign w_scored       = (r_state == ST_PLAY) & ball_hit & ~ball_miss;
  assign w_state_change = (w_next_state != r_state);

  // Next-state decode for the game flow.
  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch forms.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_OVER: if (w_start) w_next_state = ST_SERVE;
      ST_SERVE: if (w_tick_counted && r_cnt == SERVE_LAST) w_next_state = ST_PLAY;
      ST_PLAY:  if (ball_miss) w_next_state = (r_lives <= 3'd1) ? ST_OVER : ST_POINT;
      ST_POINT: if (w_tick_counted && r_cnt == POINT_LAST) w_next_state = ST_SERVE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Two-digit BCD increment that saturates at 99.
  always_comb begin
    w_score_inc = r_score;
    if (r_score == 8'h99)
      w_score_inc = 8'h99;
    else if (r_score[3:0] == 4'd9)
      w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
    else
      w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
  end

  // Game state, frame counter, score and lives; outputs registered from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_entry      <= 1'b0;
      r_cnt        <= 8'd0;
      r_score      <= 8'h00;
      r_lives      <= LIVES_INIT;
      r_run_en     <= 1'b0;
      r_ball_reset <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_entry      <= w_state_change;
      r_run_en     <= (w_next_state == ST_PLAY);
      r_game_over  <= (w_next_state == ST_OVER);
      r_ball_reset <= w_state_change && (w_next_state == ST_SERVE);

      // The first cycle in a state is flagged by r_entry so a tick there is skipped.
      if (w_state_change)
        r_cnt <= 8'd0;
      else if ((r_state == ST_SERVE || r_state == ST_POINT) && w_tick_counted)
        r_cnt <= r_cnt + 8'd1;

      // A miss takes priority over a simultaneous hit.
      if (w_game_start) begin
        r_score <= 8'h00;
        r_lives <= LIVES_INIT;
      end else if (w_lose_life) begin
        r_lives <= r_lives - 3'd1;
      end else if (w_scored) begin
        r_score <= w_score_inc;
      end
    end
  end

`ifdef PONG_SPEEDUP_EN
  localparam logic [7:0] HIT_LAST  = 8'(HITS_PER_LEVEL - 1);
  localparam logic [1:0] LEVEL_CAP = 2'(MAX_LEVEL);

  logic [7:0] r_hit_cnt;
  logic [1:0] r_level;

  // Count paddle hits and step the speed level, saturating at LEVEL_CAP.
  always_ff @(posedge clk) begin
    if (reset || w_game_start) begin
      r_hit_cnt <= 8'd0;
      r_level   <= 2'd0;
    end else if (w_scored) begin
      if (r_hit_cnt == HIT_LAST) begin
        r_hit_cnt <= 8'd0;
        if (r_level != LEVEL_CAP) r_level <= r_level + 2'd1;
      end else begin
        r_hit_cnt <= r_hit_cnt + 8'd1;
      end
    end
  end

  assign level = r_level;
`else
  assign level = 2'd0;
`endif

  assign state      = r_state;
  assign run_en     = r_run_en;
  assign ball_reset = r_ball_reset;
  assign score_bcd  = r_score;
  assign lives      = r_lives;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl - scoreboard bench for pong_game_ctrl.
// Stimulus queues the expected output vector for a given cycle; a monitor
// compares on the falling edge of that cycle.
module tb_pong_game_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic       clk, rst, btn, ft, hit, miss;
  logic [2:0] st;
  logic       run_en, ball_reset, game_over;
  logic [7:0] score_bcd;
  logic [2:0] lives;
  logic [1:0] level;

  pong_game_ctrl #(
    .LIVES(2), .SERVE_FRAMES(4), .POINT_FRAMES(3), .HITS_PER_LEVEL(2), .MAX_LEVEL(3)
  ) dut (
    .clk(clk), .reset(rst), .ready_button(btn), .frame_tick(ft),
    .ball_hit(hit), .ball_miss(miss), .state(st), .run_en(run_en),
    .ball_reset(ball_reset), .score_bcd(score_bcd), .lives(lives),
    .level(level), .game_over(game_over)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [18:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Score after the k-th consecutive hit from zero, and level with two hits per step.
  logic [7:0] score_tab [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                 8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
  logic [1:0] lvl_tab   [12] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3,
                                 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] xl(input logic [1:0] v);
`ifdef PONG_SPEEDUP_EN
    return v;
`else
    return 2'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input string nm, input logic [2:0] s,
                           input logic run, input logic br, input logic [7:0] sc,
                           input logic [2:0] lv, input logic [1:0] lev, input logic go);
    exp_t e;
    int   k;
    e.cyc  = cyc + dly;
    e.name = nm;
    e.val  = {s, run, br, sc, lv, lev, go};
    k = sb.size();
    while (k > 0 && sb[k-1].cyc > e.cyc) k--;
    sb.insert(k, e);
  endtask

  // Called in the SERVE entry cycle; a tick there is not counted, then four ticks.
  task automatic serve_to_play(input logic [7:0] sc, input logic [2:0] lv, input logic [1:0] lev);
    ft = 1'b1; tick(); ft = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ft = 1'b1;
      if (i == 3) expect_at(1, "serve_release", S_PLAY, 1'b1, 1'b0, sc, lv, lev, 1'b0);
      else        expect_at(1, "serve_counting", S_SERVE, 1'b0, 1'b0, sc, lv, lev, 1'b0);
      tick(); ft = 1'b0;
      if (i < 3) tick();
    end
  endtask

  // Called in the POINT entry cycle; a hit and tick there are ignored, then three ticks.
  task automatic point_to_serve(input logic [7:0] sc, input logic [2:0] lv, input logic [1:0] lev);
    hit = 1'b1; ft = 1'b1; tick(); hit = 1'b0; ft = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ft = 1'b1;
      if (i == 2) begin
        expect_at(1, "point_release", S_SERVE, 1'b0, 1'b1, sc, lv, lev, 1'b0);
        expect_at(2, "serve_single_pulse", S_SERVE, 1'b0, 1'b0, sc, lv, lev, 1'b0);
      end else begin
        expect_at(1, "point_counting", S_POINT, 1'b0, 1'b0, sc, lv, lev, 1'b0);
      end
      tick(); ft = 1'b0;
      if (i < 2) tick();
    end
  endtask

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t        e;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e   = sb.pop_front();
        act = {st, run_en, ball_reset, score_bcd, lives, level, game_over};
        n_checks++;
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: due at cycle %0d, not sampled (now %0d)", e.name, e.cyc, cyc);
        end else if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s @cycle %0d: got 0x%05h want 0x%05h (state,run_en,ball_reset,score,lives,level,game_over)",
                   e.name, cyc, act, e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn = 1'b1; ft = 1'b0; hit = 1'b0; miss = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    expect_at(0, "reset_state", S_IDLE, 1'b0, 1'b0, 8'h00, 3'd2, 2'd0, 1'b0);

    // Button held through reset must not start a game.
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_at(0, "held_button_idle", S_IDLE, 1'b0, 1'b0, 8'h00, 3'd2, 2'd0, 1'b0);
    end

    // Release then press: SERVE with one ball_reset three cycles after the edge.
    btn = 1'b0; repeat (4) tick();
    btn = 1'b1;
    expect_at(2, "press_wait", S_IDLE, 1'b0, 1'b0, 8'h00, 3'd2, 2'd0, 1'b0);
    expect_at(3, "press_serve", S_SERVE, 1'b0, 1'b1, 8'h00, 3'd2, 2'd0, 1'b0);
    expect_at(4, "press_pulse_end", S_SERVE, 1'b0, 1'b0, 8'h00, 3'd2, 2'd0, 1'b0);
    repeat (3) tick();
    serve_to_play(8'h00, 3'd2, 2'd0);

    // Twelve hits, then on to 99 and one saturating hit.
    for (int i = 0; i < 12; i++) begin
      hit = 1'b1;
      expect_at(1, "hit_count", S_PLAY, 1'b1, 1'b0, score_tab[i], 3'd2, xl(lvl_tab[i]), 1'b0);
      tick();
    end
    repeat (87) tick();
    expect_at(0, "score_99", S_PLAY, 1'b1, 1'b0, 8'h99, 3'd2, xl(2'd3), 1'b0);
    expect_at(1, "score_saturate", S_PLAY, 1'b1, 1'b0, 8'h99, 3'd2, xl(2'd3), 1'b0);
    tick();
    hit = 1'b0;

    // Miss with two lives: POINT, then back through SERVE to PLAY.
    miss = 1'b1;
    expect_at(1, "miss_to_point", S_POINT, 1'b0, 1'b0, 8'h99, 3'd1, xl(2'd3), 1'b0);
    tick(); miss = 1'b0;
    point_to_serve(8'h99, 3'd1, xl(2'd3));
    serve_to_play(8'h99, 3'd1, xl(2'd3));

    // Last life lost: OVER holds score; hit/miss/tick there are ignored.
    miss = 1'b1;
    expect_at(1, "miss_to_over", S_OVER, 1'b0, 1'b0, 8'h99, 3'd0, xl(2'd3), 1'b1);
    tick(); miss = 1'b0;
    hit = 1'b1; miss = 1'b1; ft = 1'b1;
    tick();
    hit = 1'b0; miss = 1'b0; ft = 1'b0;
    expect_at(0, "over_ignores_events", S_OVER, 1'b0, 1'b0, 8'h99, 3'd0, xl(2'd3), 1'b1);

    // Restart from OVER.
    btn = 1'b0; repeat (3) tick();
    btn = 1'b1;
    expect_at(2, "over_wait", S_OVER, 1'b0, 1'b0, 8'h99, 3'd0, xl(2'd3), 1'b1);
    expect_at(3, "restart_serve", S_SERVE, 1'b0, 1'b1, 8'h00, 3'd2, 2'd0, 1'b0);
    repeat (3) tick();
    serve_to_play(8'h00, 3'd2, 2'd0);

    // A start edge during PLAY is ignored.
    btn = 1'b0; repeat (3) tick();
    btn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_at(0, "play_ignores_start", S_PLAY, 1'b1, 1'b0, 8'h00, 3'd2, 2'd0, 1'b0);
    end

    // Five hits, then hit and miss together: miss wins.
    for (int i = 0; i < 5; i++) begin
      hit = 1'b1;
      expect_at(1, "hit_game2", S_PLAY, 1'b1, 1'b0, score_tab[i], 3'd2, xl(lvl_tab[i]), 1'b0);
      tick();
    end
    miss = 1'b1;
    expect_at(1, "hit_and_miss", S_POINT, 1'b0, 1'b0, 8'h05, 3'd1, xl(2'd2), 1'b0);
    tick(); hit = 1'b0; miss = 1'b0;
    point_to_serve(8'h05, 3'd1, xl(2'd2));

    // Reset in the middle of the SERVE count.
    tick();
    ft = 1'b1; tick(); ft = 1'b0;
    ft = 1'b1; tick(); ft = 1'b0;
    rst = 1'b1;
    expect_at(1, "reset_mid_serve", S_IDLE, 1'b0, 1'b0, 8'h00, 3'd2, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      expect_at(0, "idle_after_reset", S_IDLE, 1'b0, 1'b0, 8'h00, 3'd2, 2'd0, 1'b0);
    end

    // A fresh game after the reset runs the full serve count.
    btn = 1'b0; repeat (4) tick();
    btn = 1'b1;
    expect_at(3, "post_reset_serve", S_SERVE, 1'b0, 1'b1, 8'h00, 3'd2, 2'd0, 1'b0);
    repeat (3) tick();
    serve_to_play(8'h00, 3'd2, 2'd0);

    repeat (3) tick();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations never sampled, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
